// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Single-outstanding instruction fetch stage. It walks the PC through instruction
//   memory one word at a time and hands each fetched word to decode through a
//   valid/ready register. A branch redirect overrides everything, including any
//   in-flight memory response.
//
// Parameters
//   RESET_PC       PC value loaded on reset
// Ports
//   clk            clock; all state changes on the rising edge
//   rst_n          asynchronous active-low reset
//   stall          blocks the start of a new fetch while high
//   branch_taken   one-cycle redirect strobe
//   branch_target  redirect PC, sampled with branch_taken
//   imem_req       instruction-memory read request (registered)
//   imem_addr      instruction-memory address, always the current PC
//   imem_ack       memory response strobe, ignored unless imem_req is high
//   imem_rdata     memory response data
//   instr_valid    instr/instr_pc hold a fetched instruction
//   instr          fetched instruction word
//   instr_pc       address of instr
//   instr_ready    decode accepts instr this cycle
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StFull
    } fetchState_t;

    fetchState_t state;
    logic [15:0] pc;

    assign imem_addr = pc;

    // All outputs except imem_addr are registers updated alongside the state, so
    // imem_req never has a combinational path from any input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= 16'h0000;
            instr_pc    <= 16'h0000;
        end else if (branch_taken) begin
            // Redirect wins: a coincident ack is dropped without advancing the PC,
            // and a coincident instr_ready has already consumed the held word.
            state       <= StIdle;
            pc          <= branch_target;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (!stall) begin
                        state    <= StReq;
                        imem_req <= 1'b1;
                    end
                end
                StReq: begin
                    // Stall is deliberately ignored here: a request in flight
                    // stays asserted until memory answers.
                    if (imem_ack) begin
                        state       <= StFull;
                        imem_req    <= 1'b0;
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + 16'h0001;
                    end
                end
                StFull: begin
                    // instr/instr_pc keep their values after consumption.
                    if (instr_ready) begin
                        state       <= StIdle;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= StIdle;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;

    int checks   = 0;
    int failures = 0;

    pc_fetch_unit #(
        .RESET_PC(16'h0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    // Memory contents model: word stored at each address.
    function automatic logic [15:0] memWord(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] word;
    } exp_t;

    exp_t expQ[$];
    bit   sbEn  = 1'b0;
    logic prevV = 1'b0;

    always @(negedge clk) begin
        if (sbEn && instr_valid && !prevV) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, want no delivery",
                         instr_pc, instr);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                chk("sb_instr_pc", {16'h0, instr_pc}, {16'h0, e.pc});
                chk("sb_instr", {16'h0, instr}, {16'h0, e.word});
            end
        end
        prevV = instr_valid;
    end

    task automatic waitReq();
        int n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        chk("req_wait", {31'h0, imem_req}, 32'h1);
    endtask

    // One complete fetch of address expPc with instr_ready held high.
    task automatic fetchOne(input logic [15:0] expPc);
        int n = 0;
        exp_t e;
        stall = 1'b0;
        waitReq();
        chk("fetch_addr", {16'h0, imem_addr}, {16'h0, expPc});
        imem_ack   = 1'b1;
        imem_rdata = memWord(expPc);
        e.pc       = expPc;
        e.word     = memWord(expPc);
        expQ.push_back(e);
        step();
        imem_ack = 1'b0;
        while (instr_valid && n < 20) begin
            step();
            n++;
        end
        chk("fetch_drain", {31'h0, instr_valid}, 32'h0);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        ack;
        logic [15:0] rdata;
        logic        rdy;
        logic        eReq;
        logic [15:0] eAddr;
        logic        eValid;
        logic [15:0] eInstr;
        logic [15:0] eIpc;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [15:0] held;
        logic [15:0] heldPc;

        //            stall br  tgt      ack  rdata    rdy  req  addr     vld  instr    ipc
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1111, 1'b0, 1'b0, 16'h0001, 1'b1, 16'h1111, 16'h0000};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b1, 16'h1111, 16'h0000};
        vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 16'h1111, 16'h0000};
        vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 16'h1111, 16'h0000};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 16'h1111, 16'h0000};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b0, 1'b0, 16'h0002, 1'b1, 16'h2222, 16'h0001};
        vecs[9]  = '{1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 16'h2222, 16'h0001};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h2222, 16'h0001};
        vecs[11] = '{1'b0, 1'b1, 16'h0200, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0200, 1'b0, 16'h2222, 16'h0001};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0200, 1'b0, 16'h2222, 16'h0001};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h3333, 1'b0, 1'b0, 16'h0201, 1'b1, 16'h3333, 16'h0200};
        vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0201, 1'b0, 16'h3333, 16'h0200};

        rst_n         = 1'b0;
        stall         = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        imem_ack      = 1'b0;
        imem_rdata    = 16'h0000;
        instr_ready   = 1'b0;
        step();
        step();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", {16'h0, imem_addr}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", {16'h0, instr}, 32'h0);
        chk("rst_ipc", {16'h0, instr_pc}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            stall         = vecs[i].stall;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            imem_ack      = vecs[i].ack;
            imem_rdata    = vecs[i].rdata;
            instr_ready   = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].eReq});
            chk($sformatf("vec%0d_addr", i), {16'h0, imem_addr}, {16'h0, vecs[i].eAddr});
            chk($sformatf("vec%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].eValid});
            chk($sformatf("vec%0d_instr", i), {16'h0, instr}, {16'h0, vecs[i].eInstr});
            chk($sformatf("vec%0d_ipc", i), {16'h0, instr_pc}, {16'h0, vecs[i].eIpc});
        end
        branch_taken = 1'b0;
        imem_ack     = 1'b0;

        // Sequential fetch from reset; first request one cycle after release.
        stall       = 1'b0;
        instr_ready = 1'b1;
        rst_n       = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        chk("first_req_after_rst", {31'h0, imem_req}, 32'h1);
        sbEn = 1'b1;
        for (int i = 0; i < 4; i++) fetchOne(16'(i));

        // Wrap-around at the top of the address space.
        branch_taken  = 1'b1;
        branch_target = 16'hFFFF;
        step();
        branch_taken = 1'b0;
        fetchOne(16'hFFFF);
        fetchOne(16'h0000);

        // Long ack latency with stall toggling.
        stall = 1'b0;
        waitReq();
        for (int i = 0; i < 5; i++) begin
            stall = i[0];
            step();
            chk("lat_req", {31'h0, imem_req}, 32'h1);
            chk("lat_addr", {16'h0, imem_addr}, 32'h0001);
            chk("lat_valid", {31'h0, instr_valid}, 32'h0);
        end
        stall      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = memWord(16'h0001);
        expQ.push_back('{16'h0001, memWord(16'h0001)});
        step();
        imem_ack = 1'b0;
        step();

        // Branch coincident with ack: the returned word must be dropped.
        waitReq();
        imem_ack      = 1'b1;
        imem_rdata    = 16'h1234;
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        step();
        imem_ack     = 1'b0;
        branch_taken = 1'b0;
        chk("brack_valid", {31'h0, instr_valid}, 32'h0);
        chk("brack_req", {31'h0, imem_req}, 32'h0);
        chk("brack_addr", {16'h0, imem_addr}, 32'h0040);
        fetchOne(16'h0040);

        // Decode back-pressure in FULL.
        instr_ready = 1'b0;
        waitReq();
        imem_ack   = 1'b1;
        imem_rdata = memWord(16'h0041);
        expQ.push_back('{16'h0041, memWord(16'h0041)});
        step();
        imem_ack = 1'b0;
        held     = memWord(16'h0041);
        heldPc   = 16'h0041;
        for (int i = 0; i < 4; i++) begin
            stall = i[0];
            step();
            chk("bp_valid", {31'h0, instr_valid}, 32'h1);
            chk("bp_instr", {16'h0, instr}, {16'h0, held});
            chk("bp_ipc", {16'h0, instr_pc}, {16'h0, heldPc});
            chk("bp_req", {31'h0, imem_req}, 32'h0);
        end
        instr_ready = 1'b1;
        step();
        chk("bp_release", {31'h0, instr_valid}, 32'h0);

        // Reset pulse in the middle of a request.
        stall = 1'b0;
        waitReq();
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'h0, imem_req}, 32'h0);
        chk("midrst_valid", {31'h0, instr_valid}, 32'h0);
        chk("midrst_instr", {16'h0, instr}, 32'h0);
        chk("midrst_ipc", {16'h0, instr_pc}, 32'h0);
        chk("midrst_addr", {16'h0, imem_addr}, 32'h0);
        #1;
        rst_n = 1'b1;
        fetchOne(16'h0000);
        fetchOne(16'h0001);

        step();
        chk("sb_empty", expQ.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL set the PC value loaded at reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 stall  input  1  SHALL block the start of a new fetch while high.
REQ-005 branch_taken  input  1  SHALL be a one-cycle redirect strobe.
REQ-006 branch_target  input  16  SHALL give the redirect PC, sampled when branch_taken=1.
REQ-007 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-008 imem_addr  output  16  SHALL equal the current PC register, combinationally.
REQ-009 imem_ack  input  1  SHALL mark imem_rdata valid; it is ignored when imem_req=0.
REQ-010 imem_rdata  input  16  SHALL be the instruction word returned by memory.
REQ-011 instr_valid  output  1  SHALL flag that instr/instr_pc hold a fetched instruction.
REQ-012 instr  output  16  SHALL be the registered instruction word.
REQ-013 instr_pc  output  16  SHALL be the registered address of instr.
REQ-014 instr_ready  input  1  SHALL indicate decode accepts instr this cycle.

Function
REQ-015 The FSM SHALL have three states: IDLE (no request), REQ (imem_req=1), FULL (instr_valid=1).
REQ-016 IDLE -> REQ when stall=0; stays IDLE while stall=1.
REQ-017 In REQ, imem_req SHALL remain 1 regardless of stall until imem_ack or branch_taken.
REQ-018 REQ with imem_ack=1: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+1, next FULL.
REQ-019 PC increment SHALL be 16-bit modulo: 16'hFFFF+1 -> 16'h0000, no flag.
REQ-020 Ack latency SHALL be unbounded; REQ holds for any number of cycles without ack.
REQ-021 FULL with instr_ready=1: instr_valid<=0, next IDLE; instr/instr_pc retain their values.
REQ-022 FULL with instr_ready=0: all outputs held stable.
REQ-023 branch_taken=1 in any state SHALL have top priority: pc<=branch_target, instr_valid<=0, next IDLE.
REQ-024 branch_taken coincident with imem_ack SHALL discard imem_rdata; pc SHALL NOT increment.
REQ-025 branch_taken coincident with instr_ready in FULL SHALL count as consumed, then redirect.
REQ-026 A request aborted by branch_taken SHALL drop imem_req the next cycle; the memory tolerates aborts.
REQ-027 Minimum steady-state throughput SHALL be one instruction per 3 cycles (IDLE, REQ+ack, FULL+ready).
REQ-028 imem_req SHALL be registered (state-decoded), never combinational from inputs.

Reset
REQ-029 rst_n=0 SHALL immediately force: pc=RESET_PC, state IDLE, imem_req=0, instr_valid=0, instr=0, instr_pc=0.
REQ-030 Reset asserted mid-REQ or mid-FULL SHALL abort the transfer; no instruction is delivered.
REQ-031 After rst_n rises, the first imem_req SHALL assert one cycle later if stall=0.

Verification
REQ-032 Reset release, stall=0, imem_ack the cycle after each req, instr_ready=1 -> instr_pc sequence 0000,0001,0002,0003 with matching instr.
REQ-033 Set pc to FFFF via branch, fetch twice -> instr_pc FFFF then 0000.
REQ-034 Hold imem_ack=0 for 5 cycles with stall toggling -> imem_req stays 1, imem_addr stable, instr_valid=0.
REQ-035 branch_taken with target 0040 coincident with imem_ack (rdata 1234) -> 1234 never appears, next instr_pc=0040.
REQ-036 instr_ready=0 for 4 cycles in FULL -> instr, instr_pc, instr_valid unchanged, imem_req=0.
REQ-037 rst_n pulsed low mid-REQ -> outputs zero immediately; fetch restarts at RESET_PC.
